score_keeper: RTL and testbench

Producer side of the score display path: accumulates the game score from point/penalty events and drives the 7-bit binary score consumed by the two-digit seven-segment display controller. Sits between game logic and the display block, owns the game-phase FSM (idle / playing / game over) and an optional high-score register. All outputs are registered. Score range is 0..MAX_SCORE, so the display never sees an out-of-range value.

---
 rtl/score_pkg.sv | 11 +
 rtl/score_keeper_rise_detect.sv | 16 +
 rtl/score_keeper.sv | 109 ++++++++++
 tb/tb_score_keeper.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared score-path definitions: FSM encoding and display-range constants.
package score_pkg;
    localparam int SCORE_W     = 7;
    localparam int DISPLAY_MAX = 99;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAYING   = 2'd1,
        GAME_OVER = 2'd2
    } state_e;
endpackage

// File: rtl/score_keeper_rise_detect.sv
// Rising-edge detector: one history flop; a held level yields a single pulse.
module rise_detect (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Sig,
    output logic o_Rise
);
    logic r_prev;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) r_prev <= 1'b0;
        else          r_prev <= i_Sig;
    end

    assign o_Rise = i_Sig & ~r_prev;
endmodule

// File: rtl/score_keeper.sv
// Game score accumulator and phase FSM feeding the two-digit display.
// Optional high-score tracking is built when SCORE_KEEPER_HIGH_SCORE_EN is defined.
module score_keeper
    import score_pkg::*;
#(
    parameter int MAX_SCORE   = 99,
    parameter int POINT_VALUE = 1
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Start,
    input  logic               i_Point,
    input  logic               i_Penalty,
    input  logic               i_Game_Over,
    output logic [SCORE_W-1:0] o_Score,
    output logic [SCORE_W-1:0] o_High_Score,
    output logic               o_Playing,
    output logic               o_Max,
    output logic               o_Changed,
    output logic               o_New_High
);
    logic w_start, w_point, w_pen, w_go;
    logic [SCORE_W:0]   w_sum;
    logic [SCORE_W-1:0] w_inc, w_dec;

    state_e             r_state;
    logic [SCORE_W-1:0] r_score;
    logic               r_playing, r_max, r_changed;

    rise_detect u_rd_start (.i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Sig(i_Start),     .o_Rise(w_start));
    rise_detect u_rd_point (.i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Sig(i_Point),     .o_Rise(w_point));
    rise_detect u_rd_pen   (.i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Sig(i_Penalty),   .o_Rise(w_pen));
    rise_detect u_rd_go    (.i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Sig(i_Game_Over), .o_Rise(w_go));

    // Sum is one bit wider so a large POINT_VALUE cannot wrap before saturation.
    assign w_sum = {1'b0, r_score} + (SCORE_W+1)'(POINT_VALUE);
    assign w_inc = (w_sum >= (SCORE_W+1)'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : w_sum[SCORE_W-1:0];
    assign w_dec = (r_score > SCORE_W'(POINT_VALUE)) ? r_score - SCORE_W'(POINT_VALUE) : '0;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state   <= IDLE;
            r_score   <= '0;
            r_playing <= 1'b0;
            r_max     <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            case (r_state)
                PLAYING: begin
                    // Game-over wins over any coincident point/penalty.
                    if (w_go) begin
                        r_state   <= GAME_OVER;
                        r_playing <= 1'b0;
                    end else if (w_point && !w_pen) begin
                        r_score   <= w_inc;
                        r_max     <= (w_inc == SCORE_W'(MAX_SCORE));
                        r_changed <= (w_inc != r_score);
                    end else if (w_pen && !w_point) begin
                        r_score   <= w_dec;
                        r_max     <= (w_dec == SCORE_W'(MAX_SCORE));
                        r_changed <= (w_dec != r_score);
                    end
                end
                default: begin
                    if (w_start) begin
                        r_state   <= PLAYING;
                        r_playing <= 1'b1;
                        r_score   <= '0;
                        r_max     <= 1'b0;
                        r_changed <= (r_score != '0);
                    end
                end
            endcase
        end
    end

    assign o_Score   = r_score;
    assign o_Playing = r_playing;
    assign o_Max     = r_max;
    assign o_Changed = r_changed;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    logic               r_go_entry, r_new_high;
    logic [SCORE_W-1:0] r_high;

    // Compare one cycle after entering GAME_OVER, against the frozen final score.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_go_entry <= 1'b0;
            r_high     <= '0;
            r_new_high <= 1'b0;
        end else begin
            r_go_entry <= (r_state == PLAYING) && w_go;
            r_new_high <= 1'b0;
            if (r_go_entry && (r_score > r_high)) begin
                r_high     <= r_score;
                r_new_high <= 1'b1;
            end
        end
    end

    assign o_High_Score = r_high;
    assign o_New_High   = r_new_high;
`else
    assign o_High_Score = '0;
    assign o_New_High   = 1'b0;
`endif
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper; a POINT_VALUE=5 instance shares the stimulus.
`timescale 1ns/1ps
module tb_score_keeper;
    logic       i_Clk = 1'b0;
    logic       i_Rst_L = 1'b0;
    logic       i_Start = 1'b0, i_Point = 1'b0, i_Penalty = 1'b0, i_Game_Over = 1'b0;
    logic [6:0] w_score, w_high, w_score5, w_high5;
    logic       w_play, w_max, w_chg, w_nh;
    logic       w_play5, w_max5, w_chg5, w_nh5;
    int         n_cmp = 0, n_bad = 0;
    int         hs_exp;

    always #5 i_Clk = ~i_Clk;

    score_keeper #(.MAX_SCORE(99), .POINT_VALUE(1)) u_dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Start(i_Start), .i_Point(i_Point),
        .i_Penalty(i_Penalty), .i_Game_Over(i_Game_Over), .o_Score(w_score),
        .o_High_Score(w_high), .o_Playing(w_play), .o_Max(w_max),
        .o_Changed(w_chg), .o_New_High(w_nh));

    score_keeper #(.MAX_SCORE(99), .POINT_VALUE(5)) u_dut5 (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Start(i_Start), .i_Point(i_Point),
        .i_Penalty(i_Penalty), .i_Game_Over(i_Game_Over), .o_Score(w_score5),
        .o_High_Score(w_high5), .o_Playing(w_play5), .o_Max(w_max5),
        .o_Changed(w_chg5), .o_New_High(w_nh5));

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic do_reset();
        i_Rst_L = 1'b0; i_Start = 0; i_Point = 0; i_Penalty = 0; i_Game_Over = 0;
        tick();
        i_Rst_L = 1'b1;
        tick();
    endtask

    task automatic start_game();
        i_Start = 1; tick(); i_Start = 0; tick();
    endtask

    task automatic points(input int n);
        for (int i = 0; i < n; i++) begin
            i_Point = 1; tick(); i_Point = 0; tick();
        end
    endtask

    task automatic penalties(input int n);
        for (int i = 0; i < n; i++) begin
            i_Penalty = 1; tick(); i_Penalty = 0; tick();
        end
    endtask

    // Ends the game and checks the high-score outcome one cycle later.
    task automatic end_game(input string tag, input int score, input int hs, input int pulse);
        i_Game_Over = 1; tick(); i_Game_Over = 0;
        chk({tag, "_playing"}, w_play, 0);
        chk({tag, "_score"}, w_score, score);
        chk({tag, "_nh_early"}, w_nh, 0);
        tick();
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
        chk({tag, "_high"}, w_high, hs);
        chk({tag, "_nh"}, w_nh, pulse);
`else
        chk({tag, "_high"}, w_high, 0);
        chk({tag, "_nh"}, w_nh, 0);
`endif
        tick();
        chk({tag, "_nh_gone"}, w_nh, 0);
    endtask

    initial begin
        #2;
        chk("rst_score", w_score, 0);
        chk("rst_play", w_play, 0);
        chk("rst_max", w_max, 0);
        chk("rst_chg", w_chg, 0);
        chk("rst_high", w_high, 0);
        do_reset();

        // Start from zero: no change pulse.
        i_Start = 1; tick();
        chk("start_play", w_play, 1);
        chk("start_chg", w_chg, 0);
        i_Start = 0; tick();

        for (int n = 1; n <= 3; n++) begin
            i_Point = 1; tick();
            chk("pt_score", w_score, n);
            chk("pt_chg", w_chg, 1);
            i_Point = 0; tick();
            chk("pt_chg_off", w_chg, 0);
            tick(); tick();
        end

        // Held level counts once.
        i_Point = 1; tick();
        chk("held_first", w_score, 4);
        for (int i = 0; i < 19; i++) tick();
        chk("held_score", w_score, 4);
        chk("held_chg", w_chg, 0);
        i_Point = 0; tick();

        penalties(4);
        chk("pen_to_zero", w_score, 0);
        i_Penalty = 1; tick();
        chk("pen_floor", w_score, 0);
        chk("pen_floor_chg", w_chg, 0);
        i_Penalty = 0; tick();

        points(10);
        chk("ten", w_score, 10);
        chk("ten5", w_score5, 50);
        i_Point = 1; i_Penalty = 1; tick();
        chk("cancel_score", w_score, 10);
        chk("cancel_chg", w_chg, 0);
        i_Point = 0; i_Penalty = 0; tick();

        // POINT_VALUE=5 saturates 95 -> 99.
        points(9);
        chk("p5_95", w_score5, 95);
        chk("p5_95_max", w_max5, 0);
        i_Point = 1; tick();
        chk("p5_sat", w_score5, 99);
        chk("p5_sat_max", w_max5, 1);
        chk("p5_sat_chg", w_chg5, 1);
        chk("p1_nomax", w_max, 0);
        i_Point = 0; tick();
        i_Point = 1; tick();
        chk("p5_hold99", w_score5, 99);
        chk("p5_hold_chg", w_chg5, 0);
        chk("p1_21", w_score, 21);
        i_Point = 0; tick();

        // High-score sequence.
        do_reset();
        start_game(); points(42);
        end_game("go42", 42, 42, 1);
        i_Start = 1; tick();
        chk("restart_score", w_score, 0);
        chk("restart_chg", w_chg, 1);
        chk("restart_play", w_play, 1);
        i_Start = 0; tick();
        points(42);
        end_game("go42b", 42, 42, 0);
        start_game(); points(43);
        end_game("go43", 43, 43, 1);

        // Game over coincident with a point.
        do_reset();
        start_game(); points(7);
        i_Point = 1; i_Game_Over = 1; tick();
        chk("gopt_score", w_score, 7);
        chk("gopt_play", w_play, 0);
        chk("gopt_chg", w_chg, 0);
        i_Point = 0; i_Game_Over = 0; tick();
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
        hs_exp = 7;
`else
        hs_exp = 0;
`endif
        chk("gopt_high", w_high, hs_exp);
        points(3);
        chk("go_ignore_pt", w_score, 7);

        // Async reset mid-game at 55 with high score 60.
        do_reset();
        start_game(); points(60);
        end_game("go60", 60, 60, 1);
        start_game(); points(55);
        chk("pre_rst_score", w_score, 55);
        @(negedge i_Clk);
        i_Rst_L = 1'b0;
        #1;
        chk("arst_score", w_score, 0);
        chk("arst_high", w_high, 0);
        chk("arst_play", w_play, 0);
        chk("arst_max", w_max, 0);
        chk("arst_chg", w_chg, 0);
        chk("arst_nh", w_nh, 0);
        i_Rst_L = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
